// File: rtl/text_banner_renderer.sv
// ============================================================================
//  Module      : text_banner_renderer
//  Description : Overlays a character-by-character revealed text banner on a
//                VGA raster. Optional blink in DONE enabled by TEXT_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_banner_renderer #(
    parameter int          NUM_CHARS     = 16,
    parameter int          SCALE_LOG2    = 0,
    parameter int          X0            = 272,
    parameter int          Y0            = 240,
    parameter int          REVEAL_FRAMES = 4,
    parameter int          BLINK_FRAMES  = 30,
    parameter logic [11:0] FG_RGB        = 12'hFFF,
    parameter logic [11:0] BG_RGB        = 12'h008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [6:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pixel_on,
    output logic [11:0] rgb
);

    localparam int          c_aw      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int          c_fc_w    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [10:0] c_x0      = 11'(X0);
    localparam logic [10:0] c_y0      = 11'(Y0);
    localparam logic [10:0] c_x_end   = 11'(X0 + NUM_CHARS * (8 << SCALE_LOG2));
    localparam logic [10:0] c_y_end   = 11'(Y0 + (16 << SCALE_LOG2));
    localparam logic [5:0]  c_num     = 6'(NUM_CHARS);
    localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(REVEAL_FRAMES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_reveal = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    // Procedural font: rows 0-1 and 14-15 blank, space is fully blank.
    function automatic logic [7:0] f_glyph(input logic [10:0] addr);
        logic [6:0] code;
        logic [3:0] row;
        code = addr[10:4];
        row  = addr[3:0];
        if (code == 7'h20 || row < 4'd2 || row > 4'd13)
            f_glyph = 8'h00;
        else
            f_glyph = {code, 1'b1} ^ {row, row};
    endfunction

    logic [1:0]        r_state, w_state_nxt;
    logic [5:0]        r_rc, w_rc_nxt;
    logic [c_fc_w-1:0] r_fc, w_fc_nxt;
    logic [6:0]        r_buf [NUM_CHARS];
    logic              w_hidden;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= 7'h20;
        end else if (wr_en && ({1'b0, wr_addr} < c_num)) begin
            r_buf[wr_addr[c_aw-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_rc    <= 6'd0;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rc    <= w_rc_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_fc_nxt    = r_fc;
        if (start) begin
            w_state_nxt = c_st_reveal;
            w_rc_nxt    = 6'd0;
            w_fc_nxt    = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_rc_nxt = 6'd0;
                    w_fc_nxt = '0;
                end
                c_st_reveal: begin
                    if (frame_tick) begin
                        if (r_fc == c_fc_last) begin
                            w_fc_nxt = '0;
                            w_rc_nxt = r_rc + 6'd1;
                            if (r_rc + 6'd1 == c_num) w_state_nxt = c_st_done;
                        end else begin
                            w_fc_nxt = r_fc + c_fc_w'(1);
                        end
                    end
                end
                c_st_done: ;
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    assign busy = (r_state == c_st_reveal);
    assign done = (r_state == c_st_done);

`ifdef TEXT_BLINK_EN
    localparam int c_bc_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_bc_w-1:0] c_bc_last = c_bc_w'(BLINK_FRAMES - 1);

    logic [c_bc_w-1:0] r_bc;
    logic              r_phase;

    // Held clear outside DONE, so entry to DONE always starts visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bc    <= '0;
            r_phase <= 1'b0;
        end else if (start || r_state != c_st_done) begin
            r_bc    <= '0;
            r_phase <= 1'b0;
        end else if (frame_tick) begin
            if (r_bc == c_bc_last) begin
                r_bc    <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bc <= r_bc + c_bc_w'(1);
            end
        end
    end

    assign w_hidden = (r_state == c_st_done) && r_phase;
`else
    assign w_hidden = 1'b0;
`endif

    logic [10:0]     w_x, w_y, w_dx, w_dy;
    logic            w_hit, w_visible;
    logic [4:0]      w_index;
    logic [2:0]      w_col;
    logic [3:0]      w_row;
    logic [c_aw-1:0] w_rd_addr;
    logic [6:0]      w_ascii;

    assign w_x   = {1'b0, x};
    assign w_y   = {1'b0, y};
    assign w_dx  = w_x - c_x0;
    assign w_dy  = w_y - c_y0;
    assign w_hit = (w_x >= c_x0) && (w_x < c_x_end) && (w_y >= c_y0) && (w_y < c_y_end)
                && (w_x < 11'd640) && (w_y < 11'd480);
    assign w_index   = 5'(w_dx >> (3 + SCALE_LOG2));
    assign w_col     = 3'(w_dx >> SCALE_LOG2);
    assign w_row     = 4'(w_dy >> SCALE_LOG2);
    assign w_rd_addr = w_hit ? w_index[c_aw-1:0] : '0;
    assign w_ascii   = r_buf[w_rd_addr];
    assign w_visible = ({1'b0, w_index} < r_rc) && !w_hidden;

    logic [10:0] r_rom_addr;
    logic [2:0]  r_col;
    logic        r_hit, r_vis, r_von;
    logic [7:0]  w_rom_data;
    logic        w_lit, w_pix;

    assign w_rom_data = f_glyph(r_rom_addr);
    assign w_lit      = w_rom_data[3'd7 - r_col];
    assign w_pix      = r_hit && r_vis && w_lit && r_von;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_addr <= 11'd0;
            r_col      <= 3'd0;
            r_hit      <= 1'b0;
            r_vis      <= 1'b0;
            r_von      <= 1'b0;
            pixel_on   <= 1'b0;
            rgb        <= 12'h000;
        end else begin
            r_rom_addr <= {w_ascii, w_row};
            r_col      <= w_col;
            r_hit      <= w_hit;
            r_vis      <= w_visible;
            r_von      <= video_on;
            pixel_on   <= w_pix;
            rgb        <= !r_von ? 12'h000 : (w_pix ? FG_RGB : BG_RGB);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_banner_renderer.sv
// ============================================================================
//  Module      : tb_text_banner_renderer
//  Description : Randomised scoreboard bench for text_banner_renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_banner_renderer;

    localparam int          N  = 16;
    localparam int          S  = 1;
    localparam int          X0 = 448;
    localparam int          Y0 = 456;
    localparam int          RF = 2;
    localparam int          BF = 3;
    localparam logic [11:0] FG = 12'hF80;
    localparam logic [11:0] BG = 12'h008;
    localparam int          W  = N * (8 << S);
    localparam int          H  = 16 << S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        video_on = 1'b0, frame_tick = 1'b0, wr_en = 1'b0, start = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [6:0]  wr_data = '0;
    logic        busy, done, pixel_on;
    logic [11:0] rgb;

    text_banner_renderer #(
        .NUM_CHARS(N), .SCALE_LOG2(S), .X0(X0), .Y0(Y0),
        .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .pixel_on(pixel_on), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic pon; logic [11:0] rgb; } pix_t;
    typedef struct { int due; logic busy; logic done; } st_t;
    pix_t pq[$];
    st_t  sq[$];
    pix_t mp;
    st_t  ms;
    int   tests = 0;
    int   fails = 0;

    // Reference model: message contents plus frame ticks counted since start.
    int m_buf [N];
    bit m_started;
    int m_ticks;

    function automatic int glyph(input int c, input int r);
        if (c == 32 || r < 2 || r > 13) return 0;
        return (((c << 1) | 1) ^ ((r << 4) | r)) & 8'hFF;
    endfunction

    function automatic int m_rc();
        if (!m_started) return 0;
        return (m_ticks / RF > N) ? N : m_ticks / RF;
    endfunction

    function automatic bit m_done();
        return m_started && (m_ticks >= N * RF);
    endfunction

    function automatic bit m_hidden();
`ifdef TEXT_BLINK_EN
        return m_done() && ((((m_ticks - N * RF) / BF) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input int xi, input int yi, input bit von, input bit tick,
                         input bit st, input bit we, input int wa, input int wd);
        bit   hit, vis, lit, pon;
        int   idx, row, col;
        pix_t p;
        st_t  s;
        @(negedge clk);
        x = 10'(xi); y = 10'(yi); video_on = von; frame_tick = tick;
        start = st; wr_en = we; wr_addr = 5'(wa); wr_data = 7'(wd);
        hit = (xi >= X0) && (xi < X0 + W) && (yi >= Y0) && (yi < Y0 + H)
           && (xi < 640) && (yi < 480);
        lit = 1'b0;
        vis = 1'b0;
        if (hit) begin
            idx = (xi - X0) >> (3 + S);
            row = ((yi - Y0) >> S) % 16;
            col = ((xi - X0) >> S) % 8;
            lit = ((glyph(m_buf[idx], row) >> (7 - col)) & 1) == 1;
            vis = (idx < m_rc()) && !m_hidden();
        end
        pon   = hit && vis && lit && von;
        p.due = cyc + 2;
        p.pon = pon;
        p.rgb = !von ? 12'h000 : (pon ? FG : BG);
        pq.push_back(p);
        if (we && wa < N) m_buf[wa] = wd;
        if (st) begin
            m_started = 1'b1;
            m_ticks   = 0;
        end else if (tick && m_started) begin
            m_ticks++;
        end
        s.due  = cyc + 1;
        s.busy = m_started && !m_done();
        s.done = m_done();
        sq.push_back(s);
    endtask

    task automatic rand_xy(output int xi, output int yi);
        xi = ($urandom_range(0, 9) < 8) ? X0 - 8 + int'($urandom_range(0, W + 15))
                                        : int'($urandom_range(0, 1023));
        yi = ($urandom_range(0, 9) < 8) ? Y0 - 4 + int'($urandom_range(0, H + 7))
                                        : int'($urandom_range(0, 1023));
    endtask

    task automatic run(input int n, input int p_start, input int p_tick, input int p_wr);
        int xi, yi, wd;
        for (int i = 0; i < n; i++) begin
            rand_xy(xi, yi);
            wd = ($urandom_range(0, 3) == 0) ? 32 : int'($urandom_range(33, 126));
            drive(xi, yi, $urandom_range(0, 9) != 0, $urandom_range(0, 999) < p_tick,
                  $urandom_range(0, 999) < p_start, $urandom_range(0, 999) < p_wr,
                  int'($urandom_range(0, 31)), wd);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        start = 1'b0; frame_tick = 1'b0; wr_en = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || pixel_on !== 1'b0 || rgb !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b pixel_on=%b rgb=%h, want 0 0 0 000",
                     busy, done, pixel_on, rgb);
        end
        pq.delete();
        sq.delete();
        for (int i = 0; i < N; i++) m_buf[i] = 32;
        m_started = 1'b0;
        m_ticks   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            mp = pq.pop_front();
            tests++;
            if (pixel_on !== mp.pon || rgb !== mp.rgb) begin
                fails++;
                $display("FAIL pixel @cyc %0d: got pixel_on=%b rgb=%h, want pixel_on=%b rgb=%h",
                         cyc, pixel_on, rgb, mp.pon, mp.rgb);
            end
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            ms = sq.pop_front();
            tests++;
            if (busy !== ms.busy || done !== ms.done) begin
                fails++;
                $display("FAIL status @cyc %0d: got busy=%b done=%b, want busy=%b done=%b",
                         cyc, busy, done, ms.busy, ms.done);
            end
        end
    end

    initial begin
        int xi, yi;
        do_reset();
        run(40, 0, 300, 0);
        // "AB" in slots 0 and 1, then reveal through DONE and blink phases
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b0, 1'b0, 1'b1, 0, 7'h41);
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b0, 1'b0, 1'b1, 1, 7'h42);
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        run(600, 0, 300, 0);
        // restart in DONE with a coincident tick and an out-of-range write
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b1, 1'b1, 1'b1, 20, 7'h5A);
        run(300, 0, 300, 150);
        run(3000, 4, 330, 120);
        // abort mid-reveal, then reveal an all-blank buffer
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b0, 1'b1, 1'b1, 3, 7'h4D);
        run(20, 0, 500, 300);
        do_reset();
        rand_xy(xi, yi); drive(xi, yi, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        run(400, 0, 300, 0);
        run(2000, 4, 330, 120);
        repeat (4) @(negedge clk);
        if (pq.size() != 0 || sq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", pq.size() + sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
